collision_detector: RTL and testbench
=====================================

// Module: collision_detector
// PURPOSE
//  Pixel-domain collision judge sitting downstream of the dino and danger sprite
//  generators and upstream of the object controller. It watches the per-pixel
//  sprite colours, counts dino/danger overlap pixels per VGA frame, and confirms a
//  hit only after several consecutive frames exceed a threshold (glitch immunity).
//  The sticky is_colision drives the game-over path in the object controller.
// PARAMETERS
//  H_TOTAL      800     pixels per line incl. blanking (h_cnt range 0..H_TOTAL-1)
//  V_TOTAL      525     lines per frame incl. blanking (v_cnt range 0..V_TOTAL-1)
//  TRANSPARENT  12'hFFF sprite colour meaning "no sprite here" (AND-compositing white)
//  THRESH       4       overlap pixels in one frame needed to mark that frame as hit
//  CONFIRM      2       consecutive hit frames needed to latch a collision (1..7)
// PORTS
//  clk          in   1   system clock (100 MHz)
//  rst          in   1   asynchronous, active-low reset
//  pix_en       in   1   one-cycle pixel strobe; h_cnt/v_cnt/RGB sampled only when high
//  valid        in   1   VGA active-area flag from the VGA controller
//  h_cnt        in   10  current pixel column
//  v_cnt        in   10  current pixel row
//  dino_rgb     in   12  dino sprite colour {R,G,B} at (h_cnt,v_cnt)
//  danger_rgb   in   12  danger sprite colour {R,G,B} at (h_cnt,v_cnt)
//  game_state   in   2   0=IDLE, 1=PLAY, 2=OVER, 3=reserved (treated as IDLE)
//  is_colision  out  1   sticky collision flag
//  hit_pulse    out  1   one-clk pulse on the cycle is_colision rises
//  frame_ovl    out  10  overlap count of the last completed frame (saturating)
// BEHAVIOUR
//  Reset (rst=0, async): is_colision=0, hit_pulse=0, frame_ovl=0, internal overlap
//   counter=0, consecutive-frame counter=0, FSM=DISARMED.
//  Overlap pixel: pix_en && valid && dino_rgb!=TRANSPARENT && danger_rgb!=TRANSPARENT.
//  Overlap counter (10b): +1 per overlap pixel, saturates at 1023, never wraps.
//  Frame end: pix_en && h_cnt==H_TOTAL-1 && v_cnt==V_TOTAL-1. On that cycle:
//   - frame_ovl <= counter (+1 if the frame-end pixel itself overlaps, saturated);
//   - counter <= 0; the frame is a "hit frame" iff that total >= THRESH.
//  FSM (registered, updates only on clk edges):
//   DISARMED: game_state!=PLAY. Counters held at 0, is_colision=0.
//             -> ARMED when game_state==PLAY (counting starts next cycle, first
//             partial frame is counted normally).
//   ARMED:    at frame end: hit frame -> consec+1, else consec<=0.
//             When consec reaches CONFIRM -> HIT, is_colision<=1, hit_pulse=1 for
//             exactly one clk (same cycle is_colision goes high).
//             game_state==IDLE -> DISARMED; game_state==OVER -> HIT without pulse.
//   HIT:      is_colision held 1, counters frozen, frame_ovl still updates.
//             game_state==IDLE (or 3) -> DISARMED, is_colision<=0 next cycle.
//             PLAY or OVER -> stay HIT (a restart must pass through IDLE).
//  Latency: is_colision rises on the clk after the frame-end strobe of the
//   CONFIRM-th consecutive hit frame.
//  Simultaneous: game_state change and frame end on the same cycle -> state change
//   wins; no hit is latched on that cycle.
//  Non-PLAY frames never count toward consec; pix_en=0 cycles never alter counters.
//  Outputs are registered; no combinational input->output path.
// TESTING
//  1 Reset: rst=0 mid-frame with counts pending -> all outputs 0 immediately, FSM
//    DISARMED; release with game_state=PLAY -> ARMED, is_colision stays 0.
//  2 PLAY, CONFIRM=2, THRESH=4: 4 overlap px in frame N and 5 in N+1 -> frame_ovl=4
//    then 5, is_colision=1 one clk after end of N+1, hit_pulse high exactly 1 clk.
//  3 PLAY: 3 overlap px per frame for 10 frames -> is_colision stays 0, frame_ovl=3.
//  4 Hit frame, miss frame (0 px), hit frame -> consec resets, no collision;
//    following hit frame -> collision latches.
//  5 Overlap only when valid=0 or one RGB=12'hFFF -> frame_ovl=0, no collision;
//    2000 overlap px in one frame -> frame_ovl=1023 (saturated).
//  6 HIT, game_state PLAY->OVER->PLAY -> is_colision stays 1; ->IDLE -> 0 next clk,
//    then PLAY -> ARMED with consec=0.

Source files
------------

// File: rtl/collision_detector.sv
// Collision judge: counts per-frame dino/danger overlap pixels and latches a
// sticky collision after CONFIRM consecutive frames reach THRESH overlap pixels.
module collision_detector #(
  parameter int unsigned   H_TOTAL     = 800,
  parameter int unsigned   V_TOTAL     = 525,
  parameter logic [11:0]   TRANSPARENT = 12'hFFF,
  parameter int unsigned   THRESH      = 4,
  parameter int unsigned   CONFIRM     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic        valid,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic [11:0] dino_rgb,
  input  logic [11:0] danger_rgb,
  input  logic [1:0]  game_state,
  output logic        is_colision,
  output logic        hit_pulse,
  output logic [9:0]  frame_ovl
);

  localparam logic [9:0] HLast     = 10'(H_TOTAL - 1);
  localparam logic [9:0] VLast     = 10'(V_TOTAL - 1);
  localparam logic [9:0] Thresh    = 10'(THRESH);
  localparam logic [2:0] Confirm   = 3'(CONFIRM);
  localparam logic [9:0] CntMax    = 10'h3FF;

  localparam logic [1:0] GsPlay    = 2'd1;
  localparam logic [1:0] GsOver    = 2'd2;

  typedef enum logic [1:0] {
    StDisarmed = 2'd0,
    StArmed    = 2'd1,
    StHit      = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [9:0] ovl_cnt_q, ovl_cnt_d;
  logic [2:0] consec_q, consec_d;
  logic [9:0] frame_ovl_q, frame_ovl_d;
  logic       is_col_q, is_col_d;
  logic       hit_pulse_q, hit_pulse_d;

  logic       ovl_px;
  logic       frame_end;
  logic [9:0] cnt_inc;
  logic       frame_hit;
  logic [2:0] consec_inc;
  logic       gs_play;
  logic       gs_over;
  logic       gs_idle;

  // Per-pixel decode: overlap pixel, frame-end strobe and saturating count.
  always_comb begin
    ovl_px     = pix_en && valid && (dino_rgb != TRANSPARENT) && (danger_rgb != TRANSPARENT);
    frame_end  = pix_en && (h_cnt == HLast) && (v_cnt == VLast);
    // cnt_inc already folds in the frame-end pixel, so it is also the frame total
    cnt_inc    = (ovl_px && (ovl_cnt_q != CntMax)) ? ovl_cnt_q + 10'd1 : ovl_cnt_q;
    frame_hit  = (cnt_inc >= Thresh);
    consec_inc = consec_q + 3'd1;
    gs_play    = (game_state == GsPlay);
    gs_over    = (game_state == GsOver);
    // reserved encoding 3 behaves like IDLE
    gs_idle    = !gs_play && !gs_over;
  end

  // Next-state logic; a game_state change takes priority over a frame end.
  always_comb begin
    state_d     = state_q;
    ovl_cnt_d   = ovl_cnt_q;
    consec_d    = consec_q;
    frame_ovl_d = frame_ovl_q;
    is_col_d    = is_col_q;
    hit_pulse_d = 1'b0;

    unique case (state_q)
      StDisarmed: begin
        ovl_cnt_d = 10'd0;
        consec_d  = 3'd0;
        is_col_d  = 1'b0;
        if (gs_play) begin
          state_d = StArmed;
        end
      end

      StArmed: begin
        if (gs_idle) begin
          state_d   = StDisarmed;
          ovl_cnt_d = 10'd0;
          consec_d  = 3'd0;
          is_col_d  = 1'b0;
        end else if (gs_over) begin
          // game over decided elsewhere: go sticky without announcing a hit
          state_d  = StHit;
          is_col_d = 1'b1;
        end else if (frame_end) begin
          frame_ovl_d = cnt_inc;
          ovl_cnt_d   = 10'd0;
          if (frame_hit) begin
            consec_d = consec_inc;
            if (consec_inc >= Confirm) begin
              state_d     = StHit;
              is_col_d    = 1'b1;
              hit_pulse_d = 1'b1;
            end
          end else begin
            consec_d = 3'd0;
          end
        end else begin
          ovl_cnt_d = cnt_inc;
        end
      end

      StHit: begin
        if (gs_idle) begin
          state_d   = StDisarmed;
          ovl_cnt_d = 10'd0;
          consec_d  = 3'd0;
          is_col_d  = 1'b0;
        end else begin
          // consec frozen; overlap counting continues so frame_ovl stays live
          is_col_d = 1'b1;
          if (frame_end) begin
            frame_ovl_d = cnt_inc;
            ovl_cnt_d   = 10'd0;
          end else begin
            ovl_cnt_d = cnt_inc;
          end
        end
      end

      default: begin
        state_d   = StDisarmed;
        ovl_cnt_d = 10'd0;
        consec_d  = 3'd0;
        is_col_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StDisarmed;
      ovl_cnt_q   <= 10'd0;
      consec_q    <= 3'd0;
      frame_ovl_q <= 10'd0;
      is_col_q    <= 1'b0;
      hit_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ovl_cnt_q   <= ovl_cnt_d;
      consec_q    <= consec_d;
      frame_ovl_q <= frame_ovl_d;
      is_col_q    <= is_col_d;
      hit_pulse_q <= hit_pulse_d;
    end
  end

  assign is_colision = is_col_q;
  assign hit_pulse   = hit_pulse_q;
  assign frame_ovl   = frame_ovl_q;

endmodule

// File: tb/tb_collision_detector.sv
// Scoreboard bench for collision_detector: stimulus pushes expected outputs,
// monitors pop and compare at frame ends, game_state changes and reset.
module tb_collision_detector;

  localparam logic [1:0] GsIdle = 2'd0;
  localparam logic [1:0] GsPlay = 2'd1;
  localparam logic [1:0] GsOver = 2'd2;
  localparam logic [1:0] GsRsvd = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_en = 1'b0;
  logic        valid = 1'b0;
  logic [9:0]  h_cnt = 10'd0;
  logic [9:0]  v_cnt = 10'd0;
  logic [11:0] dino_rgb = 12'hFFF;
  logic [11:0] danger_rgb = 12'hFFF;
  logic [1:0]  game_state = GsIdle;
  logic        is_colision;
  logic        hit_pulse;
  logic [9:0]  frame_ovl;

  collision_detector dut (
    .clk         (clk),
    .rst         (rst),
    .pix_en      (pix_en),
    .valid       (valid),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .dino_rgb    (dino_rgb),
    .danger_rgb  (danger_rgb),
    .game_state  (game_state),
    .is_colision (is_colision),
    .hit_pulse   (hit_pulse),
    .frame_ovl   (frame_ovl)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] ovl;
    logic       col;
    logic       pulse;
  } exp_t;

  exp_t  sb[$];
  string sb_name[$];
  int    checks = 0;
  int    failures = 0;
  logic  pulse_chk = 1'b0;
  logic  [1:0] gs_prev = GsIdle;

  task automatic push(input string name, input logic [9:0] ovl, input logic col,
                      input logic pulse);
    exp_t e;
    e.ovl = ovl; e.col = col; e.pulse = pulse;
    sb.push_back(e);
    sb_name.push_back(name);
  endtask

  task automatic check_event();
    exp_t  e;
    string n;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event: ovl=%0d col=%b pulse=%b, required no event",
               frame_ovl, is_colision, hit_pulse);
    end else begin
      e = sb.pop_front();
      n = sb_name.pop_front();
      if ({frame_ovl, is_colision, hit_pulse} !== {e.ovl, e.col, e.pulse}) begin
        failures++;
        $display("FAIL %s: ovl=%0d col=%b pulse=%b, required ovl=%0d col=%b pulse=%b",
                 n, frame_ovl, is_colision, hit_pulse, e.ovl, e.col, e.pulse);
      end
      if (e.pulse) pulse_chk = 1'b1;
    end
  endtask

  // Monitor: an output event is a frame-end strobe or game_state change seen at a clock edge.
  initial begin
    logic ev;
    forever begin
      @(posedge clk);
      ev = rst && ((pix_en && h_cnt == 10'd799 && v_cnt == 10'd524) ||
                   (game_state != gs_prev));
      gs_prev = game_state;
      #1;
      if (pulse_chk) begin
        checks++;
        pulse_chk = 1'b0;
        if (hit_pulse !== 1'b0) begin
          failures++;
          $display("FAIL pulse_width: hit_pulse=%b, required 0", hit_pulse);
        end
      end
      if (ev) check_event();
    end
  end

  // Monitor: asynchronous reset must clear outputs without waiting for a clock.
  initial begin
    forever begin
      @(negedge rst);
      #1;
      check_event();
    end
  end

  // kind: 0 overlap, 1 overlap colours but valid=0, 2 dino transparent,
  // 3 danger transparent, 4 no sprites
  task automatic set_kind(input int kind);
    valid      = (kind != 1);
    dino_rgb   = (kind == 2 || kind == 4) ? 12'hFFF : 12'h0F0;
    danger_rgb = (kind == 3 || kind == 4) ? 12'hFFF : 12'hF00;
  endtask

  task automatic idle_inputs();
    pix_en = 1'b0;
    set_kind(4);
  endtask

  task automatic drive_px(input int n, input int kind);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pix_en = 1'b1;
      h_cnt  = 10'd10;
      v_cnt  = 10'd10;
      set_kind(kind);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic frame_end(input string name, input logic ovl_last, input logic [1:0] gs,
                           input logic [9:0] e_ovl, input logic e_col, input logic e_pulse);
    push(name, e_ovl, e_col, e_pulse);
    @(negedge clk);
    pix_en     = 1'b1;
    h_cnt      = 10'd799;
    v_cnt      = 10'd524;
    game_state = gs;
    set_kind(ovl_last ? 0 : 4);
    @(negedge clk);
    idle_inputs();
    repeat (3) @(negedge clk);
  endtask

  task automatic set_gs(input string name, input logic [1:0] gs,
                        input logic [9:0] e_ovl, input logic e_col, input logic e_pulse);
    push(name, e_ovl, e_col, e_pulse);
    @(negedge clk);
    game_state = gs;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    // power-on reset
    push("reset_initial", 10'd0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // two consecutive hit frames latch a collision
    set_gs("arm", GsPlay, 10'd0, 1'b0, 1'b0);
    drive_px(4, 0);
    frame_end("hit_frame_n", 1'b0, GsPlay, 10'd4, 1'b0, 1'b0);
    drive_px(4, 0);
    frame_end("hit_frame_n1", 1'b1, GsPlay, 10'd5, 1'b1, 1'b1);

    // sticky through OVER/PLAY, frame_ovl still live, cleared by IDLE
    set_gs("hit_over", GsOver, 10'd5, 1'b1, 1'b0);
    set_gs("hit_play", GsPlay, 10'd5, 1'b1, 1'b0);
    drive_px(2, 0);
    frame_end("hit_frame_ovl", 1'b0, GsPlay, 10'd2, 1'b1, 1'b0);
    set_gs("hit_idle", GsIdle, 10'd2, 1'b0, 1'b0);
    drive_px(6, 0);
    frame_end("idle_frame", 1'b0, GsIdle, 10'd2, 1'b0, 1'b0);
    set_gs("rearm", GsPlay, 10'd2, 1'b0, 1'b0);

    // hit, miss, hit: consecutive count restarts; next hit latches
    drive_px(4, 0);
    frame_end("hmh_hit1", 1'b0, GsPlay, 10'd4, 1'b0, 1'b0);
    frame_end("hmh_miss", 1'b0, GsPlay, 10'd0, 1'b0, 1'b0);
    drive_px(5, 0);
    frame_end("hmh_hit2", 1'b0, GsPlay, 10'd5, 1'b0, 1'b0);
    drive_px(4, 0);
    frame_end("hmh_hit3", 1'b0, GsPlay, 10'd4, 1'b1, 1'b1);
    set_gs("hmh_idle", GsIdle, 10'd4, 1'b0, 1'b0);
    set_gs("hmh_play", GsPlay, 10'd4, 1'b0, 1'b0);

    // below threshold forever
    for (int f = 0; f < 10; f++) begin
      drive_px(3, 0);
      frame_end("below_thresh", 1'b0, GsPlay, 10'd3, 1'b0, 1'b0);
    end

    // non-overlap qualifiers and saturation
    drive_px(5, 1);
    drive_px(5, 2);
    drive_px(5, 3);
    frame_end("no_overlap", 1'b0, GsPlay, 10'd0, 1'b0, 1'b0);
    drive_px(2000, 0);
    frame_end("saturate", 1'b1, GsPlay, 10'd1023, 1'b0, 1'b0);
    frame_end("last_px_only", 1'b1, GsPlay, 10'd1, 1'b0, 1'b0);

    // frame end coinciding with IDLE: state change wins, no latch
    drive_px(4, 0);
    frame_end("simul_pre", 1'b0, GsPlay, 10'd4, 1'b0, 1'b0);
    drive_px(5, 0);
    frame_end("simul_idle", 1'b0, GsIdle, 10'd4, 1'b0, 1'b0);
    set_gs("simul_play", GsPlay, 10'd4, 1'b0, 1'b0);
    drive_px(4, 0);
    frame_end("simul_post", 1'b0, GsPlay, 10'd4, 1'b0, 1'b0);

    // reset mid-frame with overlap count and consec pending, released in PLAY
    drive_px(3, 0);
    push("reset_midframe", 10'd0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    drive_px(4, 0);
    frame_end("post_reset_1", 1'b0, GsPlay, 10'd4, 1'b0, 1'b0);
    drive_px(4, 0);
    frame_end("post_reset_2", 1'b1, GsPlay, 10'd5, 1'b1, 1'b1);

    // reserved state disarms; OVER from ARMED goes HIT without pulse
    set_gs("rsvd_disarm", GsRsvd, 10'd5, 1'b0, 1'b0);
    set_gs("rsvd_play", GsPlay, 10'd5, 1'b0, 1'b0);
    set_gs("armed_over", GsOver, 10'd5, 1'b1, 1'b0);
    set_gs("over_idle", GsIdle, 10'd5, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: pending=%0d, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
